sklansky_sub_pipe: RTL and testbench
====================================

Name: sklansky_sub_pipe

Overview:
- Pipelined N-bit two's-complement subtractor: computes A - B - Bin using a Sklansky parallel-prefix borrow tree, with one register per prefix level.
- Companion to the team's combinational prefix adder. It is the inverse arithmetic direction and is used where subtraction must run at full clock rate.
- Sits between a valid/ready producer and consumer. It provides backpressure and a zero flag, an unsigned borrow flag and a signed overflow flag for downstream comparators/ALU.

Parameters:
- N, 8, operand width. N >= 2; N need not be a power of two.
- LVL, $clog2(N), number of prefix levels. Derived; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  N  minuend.
- B  in  N  subtrahend.
- Bin  in  1  borrow in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- Diff  out  N  A - B - Bin mod 2^N.
- Bout  out  1  borrow out: 1 when A < B + Bin, unsigned.
- Ovf  out  1  signed overflow of A - B - Bin.
- Zero  out  1  Diff == 0.

Behaviour:
- Arithmetic: Diff = A + ~B + ~Bin, i.e. cin = ~Bin.
  - P = A ^ ~B, G = A & ~B.
  - Position 0 absorbs carry-in: G0' = G0 | (P0 & cin).
- Prefix, Sklansky topology:
  - At level j (1..LVL), bit i with i[j-1]==1 combines with index k = ((i >> (j-1)) << (j-1)) - 1.
  - Combine rule: G_i = G_i | (P_i & G_k), P_i = P_i & P_k.
  - All other bits pass through unchanged.
- Result formation:
  - Carries: C[0] = cin, C[i+1] = Gprefix[i].
  - Diff = P ^ C[N-1:0].
  - Bout = ~C[N].
  - Ovf = C[N] ^ C[N-1].
  - Zero = ~|Diff.
- Pipeline stages:
  - S0 registers P, G', P(original) and cin on acceptance.
  - S1..S_LVL each register one prefix level.
  - Output stage registers Diff/Bout/Ovf/Zero.
  - Latency L = LVL + 2 cycles from the accepting edge to out_valid (N=8: L = 5).
- Each stage carries a valid bit.
- Handshake and stall:
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en, combinational.
  - An input beat is accepted when in_valid & in_ready.
  - When en=0 all stages hold, including data and valid bits.
  - Bubbles are not collapsed: a stall freezes the whole pipe.
- Output holding rules:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - A beat leaves on out_valid & out_ready.
  - Acceptance with a simultaneous output transfer is legal at full rate: 1 beat/cycle throughput.
- Reset:
  - Asserting rst clears all valid bits and data registers to 0 immediately, without waiting for a clock.
  - out_valid=0 and Diff/Bout/Ovf/Zero=0 during reset.
  - in_ready=1 during reset (follows en), but no beat is captured while rst=1.
  - Reset mid-stream discards all in-flight beats. The first result after release corresponds to the first beat accepted after release.
- Boundaries:
  - A=B, Bin=0 gives Zero=1, Bout=0.
  - A=0, B=2^N-1, Bin=1 gives Diff=0, Bout=1.
  - in_valid=0 inserts a bubble, producing no output beat.
  - Inputs are sampled only on the accepting edge, so in_valid/A/B may change freely otherwise.

Decomposition:
- Package sklansky_pkg: LVL derivation, the prefix-partner index function (i, j) -> k, and the combine operator as a function. Shared with the existing adder.
- One sub-module, sklansky_stage: one registered prefix level.
  - Parameters N and J.
  - Ports: clk, rst, en, v_in/P_in/G_in/aux_in, v_out/P_out/G_out/aux_out.
  - Top level instantiates LVL of these via generate.

Test Plan (N=8, L=5, out_ready=1 unless stated):
1. A=0x05, B=0x03, Bin=0 -> 5 cycles later Diff=0x02, Bout=0, Ovf=0, Zero=0, out_valid for exactly one cycle.
2. A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout=1, Ovf=0; then A=0x80, B=0x01 -> Diff=0x7F, Ovf=1, Bout=0.
3. A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Zero=1, Bout=0; then A=0x00, B=0xFF, Bin=1 -> Diff=0x00, Bout=1.
4. Stream 16 random beats back-to-back -> 16 results on 16 consecutive cycles, in order, matching the reference model (A-B-Bin).
5. Same stream with out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0 on those cycles, outputs frozen, no beat lost or duplicated, order preserved.
6. Assert rst asynchronously (mid-cycle) with 3 beats in flight -> out_valid drops before the next clock edge. After release, the first beat sent returns after exactly L cycles and no stale result appears.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Sklansky prefix helpers shared by the prefix adder and subtractor.
//   partner(i, j) : index k that bit i combines with at prefix level j
//   combine(hi,lo): generate/propagate operator on {G, P} pairs
package sklansky_pkg;

  // Bit i (with i[j-1] set) pairs with the top bit of the block just below
  // its 2^(j-1)-aligned group.
  function automatic int partner(input int i, input int j);
    return ((i >> (j - 1)) << (j - 1)) - 1;
  endfunction

  // {G, P} operator: hi absorbs lo.
  function automatic logic [1:0] combine(input logic [1:0] gp_hi,
                                         input logic [1:0] gp_lo);
    return {gp_hi[1] | (gp_hi[0] & gp_lo[1]), gp_hi[0] & gp_lo[0]};
  endfunction

endpackage

// File: rtl/sklansky_stage.sv
// One registered Sklansky prefix level.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : pipeline advance; when low the stage holds
//   v_in/v_out    : beat valid
//   P_in/G_in     : group propagate/generate entering the level
//   P_out/G_out   : group propagate/generate after the level
//   aux_in/aux_out: {cin, original P}, carried alongside for result formation
module sklansky_stage
  import sklansky_pkg::*;
#(
  parameter int N = 8,
  parameter int J = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         v_in,
  input  logic [N-1:0] P_in,
  input  logic [N-1:0] G_in,
  input  logic [N:0]   aux_in,
  output logic         v_out,
  output logic [N-1:0] P_out,
  output logic [N-1:0] G_out,
  output logic [N:0]   aux_out
);

  logic [N-1:0] p_d, g_d;
  logic [N-1:0] p_q, g_q;
  logic [N:0]   aux_q;
  logic         vld_q;

  for (genvar i = 0; i < N; i++) begin : g_bit
    if (((i >> (J - 1)) & 1) == 1) begin : g_comb
      localparam int K = partner(i, J);
      assign {g_d[i], p_d[i]} = combine({G_in[i], P_in[i]}, {G_in[K], P_in[K]});
    end else begin : g_pass
      assign g_d[i] = G_in[i];
      assign p_d[i] = P_in[i];
    end
  end

  // ---- level J register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      p_q   <= '0;
      g_q   <= '0;
      aux_q <= '0;
    end else if (en) begin
      vld_q <= v_in;
      p_q   <= p_d;
      g_q   <= g_d;
      aux_q <= aux_in;
    end
  end

  assign v_out   = vld_q;
  assign P_out   = p_q;
  assign G_out   = g_q;
  assign aux_out = aux_q;

endmodule

// File: rtl/sklansky_sub_pipe.sv
// Pipelined N-bit subtractor A - B - Bin built on a Sklansky borrow tree,
// one register per prefix level, with valid/ready flow control.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready = pipeline enable)
//   A, B, Bin           : minuend, subtrahend, borrow in
//   out_valid/out_ready : result handshake
//   Diff                : A - B - Bin mod 2^N
//   Bout, Ovf, Zero     : unsigned borrow, signed overflow, Diff == 0
// Latency: $clog2(N) + 2 register stages; a stall freezes every stage.
module sklansky_sub_pipe
  import sklansky_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         Ovf,
  output logic         Zero
);

  localparam int LVL = $clog2(N);

  logic en;

  // Subtraction as A + ~B + cin with cin = ~Bin.
  logic [N-1:0] nb, p_d, g_d;
  logic         cin_d;

  assign nb    = ~B;
  assign cin_d = ~Bin;
  assign p_d   = A ^ nb;
  always_comb begin
    g_d    = A & nb;
    g_d[0] = g_d[0] | (p_d[0] & cin_d);
  end

  logic         vld_p0_q;
  logic [N-1:0] p_p0_q, g_p0_q;
  logic [N:0]   aux_p0_q;

  // ---- S0 register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      p_p0_q   <= '0;
      g_p0_q   <= '0;
      aux_p0_q <= '0;
    end else if (en) begin
      vld_p0_q <= in_valid;
      if (in_valid) begin
        p_p0_q   <= p_d;
        g_p0_q   <= g_d;
        aux_p0_q <= {cin_d, p_d};
      end
    end
  end

  logic         v_ch   [0:LVL];
  logic [N-1:0] p_ch   [0:LVL];
  logic [N-1:0] g_ch   [0:LVL];
  logic [N:0]   aux_ch [0:LVL];

  assign v_ch[0]   = vld_p0_q;
  assign p_ch[0]   = p_p0_q;
  assign g_ch[0]   = g_p0_q;
  assign aux_ch[0] = aux_p0_q;

  for (genvar j = 1; j <= LVL; j++) begin : g_lvl
    sklansky_stage #(.N(N), .J(j)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .v_in   (v_ch[j-1]),
      .P_in   (p_ch[j-1]),
      .G_in   (g_ch[j-1]),
      .aux_in (aux_ch[j-1]),
      .v_out  (v_ch[j]),
      .P_out  (p_ch[j]),
      .G_out  (g_ch[j]),
      .aux_out(aux_ch[j])
    );
  end

  // Carry vector: C[0] = cin, C[i+1] = prefix generate of bits [i:0].
  logic [N:0]   c;
  logic [N-1:0] diff_d;

  assign c      = {g_ch[LVL], aux_ch[LVL][N]};
  assign diff_d = aux_ch[LVL][N-1:0] ^ c[N-1:0];

  logic         vld_out_q;
  logic [N-1:0] diff_q;
  logic         bout_q, ovf_q, zero_q;

  // ---- output register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_out_q <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (en) begin
      vld_out_q <= v_ch[LVL];
      diff_q    <= diff_d;
      bout_q    <= ~c[N];
      ovf_q     <= c[N] ^ c[N-1];
      zero_q    <= ~|diff_d;
    end
  end

  assign en        = ~vld_out_q | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_out_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// Self-checking bench for sklansky_sub_pipe (N = 8, latency 5).
module tb_sklansky_sub_pipe;

  localparam int N = 8;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [N-1:0] A, B;
  logic         Bin;
  logic         out_valid, out_ready;
  logic [N-1:0] Diff;
  logic         Bout, Ovf, Zero;

  sklansky_sub_pipe #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Bout     (Bout),
    .Ovf      (Ovf),
    .Zero     (Zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Packing {Diff, Bout, Ovf, Zero}.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic bi);
    int ua, ub, sa, sb, sd;
    logic [7:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    d  = 8'(ua - ub - int'(bi));
    bo = (ua < ub + int'(bi));
    sd = sa - sb - int'(bi);
    ov = (sd < -128) || (sd > 127);
    return {d, bo, ov, (d == 8'h00)};
  endfunction

  typedef struct {
    logic [10:0] r;
    int          acc;
    int          st;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          stall_cnt = 0;
  logic        held = 1'b0;
  logic [11:0] held_val;

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      q.delete();
      held = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("in_ready_rule", in_ready, (!out_valid) || out_ready);
      if (held)
        chk("stall_frozen", {out_valid, Diff, Bout, Ovf, Zero}, held_val);
      if (out_valid && !held) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat: got out_valid=1 expected no beat, Diff=0x%0h", Diff);
        end else begin
          chk("latency", cyc, q[0].acc + L + (stall_cnt - q[0].st));
        end
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("result", {Diff, Bout, Ovf, Zero}, e.r);
      end
      held     = out_valid && !out_ready;
      held_val = {out_valid, Diff, Bout, Ovf, Zero};
      if (out_valid && !out_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        e.r   = model(A, B, Bin);
        e.acc = cyc;
        e.st  = stall_cnt;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int g;
    g        = 0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Bin      = bi;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      A   = 8'($urandom);
      B   = 8'($urandom);
      Bin = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    A         = 8'h05;
    B         = 8'h03;
    Bin       = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_diff", {Diff, Bout, Ovf, Zero}, 0);
    chk("reset_in_ready", in_ready, 1);

    // Pin the reference model to hand-computed values.
    chk("model_05_03", model(8'h05, 8'h03, 1'b0), {8'h02, 1'b0, 1'b0, 1'b0});
    chk("model_03_05", model(8'h03, 8'h05, 1'b0), {8'hFE, 1'b1, 1'b0, 1'b0});
    chk("model_80_01", model(8'h80, 8'h01, 1'b0), {8'h7F, 1'b0, 1'b1, 1'b0});
    chk("model_10_0F_1", model(8'h10, 8'h0F, 1'b1), {8'h00, 1'b0, 1'b0, 1'b1});
    chk("model_00_FF_1", model(8'h00, 8'hFF, 1'b1), {8'h00, 1'b1, 1'b0, 1'b1});

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    idle(2);

    // Directed beats with bubbles between them.
    send(8'h05, 8'h03, 1'b0);
    idle(8);
    send(8'h03, 8'h05, 1'b0);
    send(8'h80, 8'h01, 1'b0);
    idle(8);
    send(8'h10, 8'h0F, 1'b1);
    send(8'h00, 8'hFF, 1'b1);
    send(8'h5A, 8'h5A, 1'b0);
    idle(8);

    // Back-to-back random stream.
    for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    idle(8);

    // Random stream with random gaps.
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(8);

    // Stream with a 3-cycle output stall.
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        if (g >= 50) chk("stall_wait_timeout", 1, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(10);

    // Asynchronous reset with beats in flight.
    for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", {Diff, Bout, Ovf, Zero}, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h01, 8'h02, 1'b0);
    idle(10);

    chk("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
